// File: rtl/d_input_debouncer_if.sv
// Signal bundle between a raw data source and the input debouncer.
// glitch_cnt is present only when DEBOUNCE_GLITCH_CNT_EN is defined.
`timescale 1ns/1ps

interface d_input_debouncer_if;
    logic       d_raw;
    logic       d_out;
    logic       rise;
    logic       fall;
    logic       busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Source side: drives the raw line, observes the conditioned outputs.
    modport master (
        output d_raw,
        input  d_out,
        input  rise,
        input  fall,
        input  busy,
        input  glitch_cnt
    );

    // Debouncer side.
    modport slave (
        input  d_raw,
        output d_out,
        output rise,
        output fall,
        output busy,
        output glitch_cnt
    );
`else
    // Source side: drives the raw line, observes the conditioned outputs.
    modport master (
        output d_raw,
        input  d_out,
        input  rise,
        input  fall,
        input  busy
    );

    // Debouncer side.
    modport slave (
        input  d_raw,
        output d_out,
        output rise,
        output fall,
        output busy
    );
`endif
endinterface

// File: rtl/d_input_debouncer.sv
// Synchronises and debounces a raw data line; emits rise/fall strobes.
// Optional glitch counter: define DEBOUNCE_GLITCH_CNT_EN.
`timescale 1ns/1ps

module d_input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input logic                clk,
    input logic                reset,
    d_input_debouncer_if.slave dbus
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic                   differs;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   dout_q;
    logic                   dout_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   busy_q;
    logic                   busy_d;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign differs  = sync_bit != dout_q;

    // Metastability chain: raw line enters at bit 0, leaves at the top bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dbus.d_raw};
        end
    end

    // Qualification FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: a new level must persist DEBOUNCE_CYCLES samples to commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            ST_STABLE: begin
                if (differs) begin
                    state_d = ST_CHECK;
                    cnt_d   = CNT_ONE;
                    busy_d  = 1'b1;
                end else begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            ST_CHECK: begin
                if (!differs) begin
                    // Candidate bounced back before it qualified.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    dout_d  = sync_bit;
                    rise_d  = sync_bit;
                    fall_d  = ~sync_bit;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
        endcase
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       bounce;
    logic [7:0] glitch_q;

    assign bounce = (state_q == ST_CHECK) && !differs;

    // Saturating count of rejected candidates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_q <= 8'h00;
        end else if (bounce && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'h01;
        end
    end

    assign dbus.glitch_cnt = glitch_q;
`endif

    assign dbus.d_out = dout_q;
    assign dbus.rise  = rise_q;
    assign dbus.fall  = fall_q;
    assign dbus.busy  = busy_q;

    // Strobes are exclusive and separated by at least one idle cycle.
    a_strobe_excl: assert property (
        @(posedge clk) disable iff (!reset)
        !(rise_q && fall_q)
    );

    a_strobe_gap: assert property (
        @(posedge clk) disable iff (!reset)
        (rise_q || fall_q) |=> !(rise_q || fall_q)
    );

    // The counter stops at the commit value and never wraps.
    a_cnt_bound: assert property (
        @(posedge clk) disable iff (!reset)
        cnt_q <= CNT_LAST
    );

endmodule
